mem_arbiter: RTL and testbench

//  Shares one single-port 32-bit memory between the core's instruction-fetch port
//  and its load/store port, so the single-cycle core can run from a unified memory.

---
 rtl/mips_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared widths and the read-owner encoding for the unified-memory core.
package mips_pkg;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_e;

endpackage : mips_pkg

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter for one single-port memory with 1-cycle read latency.
// Build option MEM_ARB_RR_EN: round-robin tie break instead of data-first + MAX_WAIT.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_W,
    parameter int unsigned DATA_W   = MEM_DATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e state, state_nxt;
    logic   fetch_first;

`ifdef MEM_ARB_RR_EN
    // High when data won the most recent contested cycle, so fetch takes the next tie.
    logic rr_last_d;

    assign fetch_first = rr_last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_d <= 1'b1;
        end else if (if_req && d_req) begin
            rr_last_d <= d_gnt;
        end
    end
`else
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    assign fetch_first = (wait_cnt == WAIT_W'(MAX_WAIT));

    // Consecutive cycles fetch was pending but refused, saturating at MAX_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (if_req && !if_gnt) begin
            if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OWN_NONE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision and next read owner; nothing is granted while reset is held.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        state_nxt = OWN_NONE;
        if (!rst) begin
            if (if_req && d_req) begin
                if_gnt = fetch_first;
                d_gnt  = !fetch_first;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
        if (if_gnt) begin
            state_nxt = OWN_IF;
        end else if (d_gnt && !d_we) begin
            state_nxt = OWN_D;
        end
    end

    assign mem_en    = if_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : if_addr;
    assign mem_wdata = mem_we ? d_wdata : '0;

    assign if_rvalid = (state == OWN_IF);
    assign d_rvalid  = (state == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter (default data-first build).
module tb_mem_arbiter;
    import mips_pkg::*;

    localparam int unsigned AW       = MEM_ADDR_W;
    localparam int unsigned DW       = MEM_DATA_W;
    localparam int unsigned DEPTH    = 1 << AW;
    localparam int          MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];

    // Reference model state
    int            refused = 0;
    logic          exp_if_rv = 1'b0;
    logic          exp_d_rv = 1'b0;
    logic [DW-1:0] exp_rdata = '0;

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(32'hA5C3_0000 ^ (i * 32'h0001_0207));
    endfunction

    // Single-port memory, loaded with a known pattern while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= pat(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict grants from the arbitration rules, compare, then advance the model.
    task automatic step(output logic ig, output logic dg);
        logic e_ig, e_dg;
        @(negedge clk);
        e_dg = d_req && !(if_req && refused >= MAX_WAIT);
        e_ig = if_req && !e_dg;
        check("if_gnt", DW'(if_gnt), DW'(e_ig));
        check("d_gnt", DW'(d_gnt), DW'(e_dg));
        check("mem_en", DW'(mem_en), DW'(e_ig | e_dg));
        check("mem_we", DW'(mem_we), DW'(e_dg & d_we));
        if (e_ig || e_dg) check("mem_addr", DW'(mem_addr), DW'(e_dg ? d_addr : if_addr));
        if (e_dg && d_we) check("mem_wdata", mem_wdata, d_wdata);
        check("if_rvalid", DW'(if_rvalid), DW'(exp_if_rv));
        check("d_rvalid", DW'(d_rvalid), DW'(exp_d_rv));
        check("if_rdata", if_rdata, exp_if_rv ? exp_rdata : '0);
        check("d_rdata", d_rdata, exp_d_rv ? exp_rdata : '0);
        exp_if_rv = e_ig;
        exp_d_rv  = e_dg && !d_we;
        if (e_ig) exp_rdata = shadow[if_addr];
        else if (e_dg && !d_we) exp_rdata = shadow[d_addr];
        if (e_dg && d_we) shadow[d_addr] = d_wdata;
        refused = (if_req && !e_ig) ? refused + 1 : 0;
        ig = e_ig;
        dg = e_dg;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = pat(i);
        exp_if_rv = 1'b0;
        exp_d_rv  = 1'b0;
        exp_rdata = '0;
        refused   = 0;
    endtask

    initial begin
        logic       ig, dg;
        logic [9:0] tie_seen;
        ig = 1'b0;
        dg = 1'b0;
        tie_seen = '0;

        do_reset();
        step(ig, dg);

        // Reset while a load is in flight
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = AW'(7);
        step(ig, dg);
        rst = 1'b1;
        #1;
        check("rst_d_gnt", DW'(d_gnt), '0);
        check("rst_if_gnt", DW'(if_gnt), '0);
        check("rst_mem_en", DW'(mem_en), '0);
        check("rst_mem_we", DW'(mem_we), '0);
        check("rst_d_rvalid", DW'(d_rvalid), '0);
        check("rst_d_rdata", d_rdata, '0);
        check("rst_if_rvalid", DW'(if_rvalid), '0);
        do_reset();
        step(ig, dg);

        // Back-to-back fetches
        for (int a = 0; a < 3; a++) begin
            if_req  = 1'b1;
            if_addr = AW'(a);
            step(ig, dg);
            check("fetch_gnt", DW'(ig), DW'(1'b1));
        end
        if_req = 1'b0;
        step(ig, dg);

        // Both requesting for 10 cycles: fetch forced in every fifth cycle
        if_req  = 1'b1;
        if_addr = AW'(20);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = AW'(21);
        for (int c = 0; c < 10; c++) begin
            step(ig, dg);
            tie_seen[c] = if_gnt_seen(ig);
        end
        check("tie_pattern", DW'(tie_seen), DW'(10'b10_0001_0000));
        if_req = 1'b0;
        d_req  = 1'b0;
        step(ig, dg);

        // Store then load of the same word
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = AW'(5);
        d_wdata = 32'hDEAD_BEEF;
        step(ig, dg);
        d_we = 1'b0;
        step(ig, dg);
        d_req = 1'b0;
        @(negedge clk);
        check("load_after_store", d_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        exp_d_rv = 1'b0;
        step(ig, dg);

        // Fetch loses once and is withdrawn: no fetch access may follow
        if_req  = 1'b1;
        if_addr = AW'(9);
        d_req   = 1'b1;
        d_addr  = AW'(10);
        step(ig, dg);
        if_req = 1'b0;
        d_req  = 1'b0;
        step(ig, dg);
        step(ig, dg);

        // Random traffic honouring the hold-until-grant protocol
        for (int n = 0; n < 3000; n++) begin
            if (!if_req || ig || $urandom_range(0, 19) == 0) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
            end
            if (!d_req || dg || $urandom_range(0, 19) == 0) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 2) == 0);
                d_addr  = AW'($urandom_range(0, 31));
                d_wdata = DW'($urandom);
            end
            step(ig, dg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic if_gnt_seen(input logic g);
        return g;
    endfunction

endmodule : tb_mem_arbiter
